// File: rtl/usb_endpoint_in_pktbuf_pkg.sv
// Local types of the IN endpoint: transaction FSM states.
package usb_endpoint_in_pktbuf_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_HS
  } InState;

endpackage

// File: rtl/usb_ep_pkg.sv
// Endpoint transfer types understood by the packet-buffered IN endpoint.
package usb_ep_pkg;

  typedef enum logic [1:0] {
    NONE,
    BULK,
    INTERRUPT,
    ISOCHRONOUS
  } EndpointType;

endpackage

// File: rtl/usb_packet_pkg.sv
// Response codes returned to the SIE; respHandshakePID_o selects handshake vs data meaning.
package usb_packet_pkg;

  localparam logic [1:0] RES_ACK   = 2'd0;
  localparam logic [1:0] RES_NAK   = 2'd1;
  localparam logic [1:0] RES_STALL = 2'd2;

  localparam logic [1:0] DATA_0 = 2'd0;
  localparam logic [1:0] DATA_1 = 2'd1;

endpackage

// File: rtl/usb_endpoint_in_pktbuf_if.sv
// SIE-facing IN path: token, response, byte stream and host handshake.
interface usb_endpoint_in_pktbuf_if;

  logic       inToken_i;
  logic       respValid_o;
  logic       respHandshakePID_o;
  logic [1:0] respPacketID_o;
  logic       popData_i;
  logic       dataAvailable_o;
  logic       isLast_o;
  logic [7:0] data_o;
  logic       txDone_i;
  logic       hsAck_i;
  logic       hsTimeout_i;

  modport master (
    output inToken_i, popData_i, txDone_i, hsAck_i, hsTimeout_i,
    input  respValid_o, respHandshakePID_o, respPacketID_o,
    input  dataAvailable_o, isLast_o, data_o
  );

  modport slave (
    input  inToken_i, popData_i, txDone_i, hsAck_i, hsTimeout_i,
    output respValid_o, respHandshakePID_o, respPacketID_o,
    output dataAvailable_o, isLast_o, data_o
  );

endinterface

// File: rtl/usb_ep_pkt_len_fifo.sv
// Length FIFO of committed packets; the head entry is the packet currently offered to the host.
module usb_ep_pkt_len_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4
) (
  input  logic                     clk12_i,
  input  logic                     rst_n_i,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushLen,
  input  logic                     pop,
  output logic [WIDTH-1:0]         headLen,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             pushEn;
  logic             popEn;

  assign pushEn  = push & ~full;
  assign popEn   = pop & ~empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign headLen = mem[rdPtr];

  always_ff @(posedge clk12_i)
    if (pushEn) mem[wrPtr] <= pushLen;

  always_ff @(posedge clk12_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      wrPtr <= wrPtr + AW'(pushEn);
      rdPtr <= rdPtr + AW'(popEn);
      count <= count + CW'(pushEn) - CW'(popEn);
    end
  end

endmodule

// File: rtl/usb_endpoint_in_pktbuf.sv
// Packet-buffered IN endpoint: whole packets are filled, offered on IN tokens, then retired on ACK
// or rewound on timeout so a retry resends identical bytes.
//
// state   | meaning
// IDLE    | waiting for an IN token; answers STALL/NAK or starts a data packet
// SEND    | streaming the head packet to the SIE
// WAIT_HS | packet sent, waiting for host ACK or handshake timeout
module usb_endpoint_in_pktbuf
  import usb_ep_pkg::*, usb_packet_pkg::*, usb_endpoint_in_pktbuf_pkg::*;
#(
  parameter EndpointType EP_TYPE      = BULK,
  parameter int          ADDR_WID     = 9,
  parameter int          MAX_PKT_SIZE = 64,
  parameter int          NUM_PKTS     = 4
) (
  input  logic                      clk12_i,
  input  logic                      rst_n_i,
  input  logic                      resetDataToggle_i,
  input  logic                      setHalt_i,
  input  logic                      clearHalt_i,
  input  logic                      fillValid_i,
  input  logic [7:0]                fillData_i,
  input  logic                      fillCommit_i,
  input  logic                      fillAbort_i,
  output logic                      full_o,
  output logic                      pktErr_o,
  output logic [$clog2(NUM_PKTS):0] pktCount_o,
  output logic                      halted_o,
  usb_endpoint_in_pktbuf_if.slave   sie
);

  localparam int PTR_WID = ADDR_WID + 1;
  localparam int LEN_WID = $clog2(MAX_PKT_SIZE + 1);
  localparam bit IS_ISO  = (EP_TYPE == ISOCHRONOUS);

  if (EP_TYPE == NONE) begin : gBadType
    $error("usb_endpoint_in_pktbuf: EP_TYPE NONE is not a usable endpoint type");
  end

  logic [7:0]         mem [2**ADDR_WID];
  logic [PTR_WID-1:0] wrSpec, wrPub, wrNext, rdSpec, rdPub, pktEnd;
  logic [LEN_WID-1:0] pktLen, headLen, pushLen;
  logic               ovf, byteTry, byteDrop, byteWr, commitOk, commitBad;
  logic               lenFull, lenEmpty, byteFull;
  logic               toggle, zlp, zlpNxt, retire, rewind, flip;
  logic               respValidNxt, respHsNxt;
  logic [1:0]         respPidNxt;
  InState             state, stateNxt;

  // Occupancy is measured against the published read pointer so the packet in flight stays reserved.
  assign byteFull  = ((wrSpec ^ rdPub) == {1'b1, {ADDR_WID{1'b0}}});
  assign full_o    = byteFull | lenFull;
  assign byteTry   = fillValid_i & ~fillAbort_i & ~ovf;
  assign byteDrop  = byteTry & (full_o | (pktLen == LEN_WID'(MAX_PKT_SIZE)));
  assign byteWr    = byteTry & ~byteDrop;
  assign commitBad = fillCommit_i & ~fillAbort_i & (ovf | byteDrop | lenFull);
  assign commitOk  = fillCommit_i & ~fillAbort_i & ~commitBad;
  assign pushLen   = pktLen + LEN_WID'(byteWr);
  assign wrNext    = wrSpec + PTR_WID'(byteWr);

  always_ff @(posedge clk12_i)
    if (byteWr) mem[wrSpec[ADDR_WID-1:0]] <= fillData_i;

  always_ff @(posedge clk12_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wrSpec   <= '0;
      wrPub    <= '0;
      pktLen   <= '0;
      ovf      <= 1'b0;
      pktErr_o <= 1'b0;
    end else begin
      pktErr_o <= commitBad;
      if (fillAbort_i || commitBad) begin
        wrSpec <= wrPub;
        pktLen <= '0;
        ovf    <= 1'b0;
      end else if (commitOk) begin
        wrSpec <= wrNext;
        wrPub  <= wrNext;
        pktLen <= '0;
        ovf    <= 1'b0;
      end else begin
        wrSpec <= wrNext;
        pktLen <= pushLen;
        if (byteDrop) ovf <= 1'b1;
      end
    end
  end

  usb_ep_pkt_len_fifo #(
    .WIDTH (LEN_WID),
    .DEPTH (NUM_PKTS)
  ) uLenFifo (
    .clk12_i (clk12_i),
    .rst_n_i (rst_n_i),
    .push    (commitOk),
    .pushLen (pushLen),
    .pop     (retire),
    .headLen (headLen),
    .full    (lenFull),
    .empty   (lenEmpty),
    .count   (pktCount_o)
  );

  assign pktEnd              = rdPub + PTR_WID'(headLen);
  assign sie.dataAvailable_o = (state == SEND) & ~zlp & (rdSpec != pktEnd);
  assign sie.isLast_o        = sie.dataAvailable_o & ((rdSpec + PTR_WID'(1)) == pktEnd);
  assign sie.data_o          = mem[rdSpec[ADDR_WID-1:0]];

  always_comb begin
    stateNxt     = state;
    respValidNxt = 1'b0;
    respHsNxt    = 1'b0;
    respPidNxt   = DATA_0;
    zlpNxt       = zlp;
    retire       = 1'b0;
    rewind       = 1'b0;
    flip         = 1'b0;
    unique case (state)
      IDLE: begin
        if (sie.inToken_i) begin
          respValidNxt = 1'b1;
          if (halted_o) begin
            respHsNxt  = 1'b1;
            respPidNxt = RES_STALL;
          end else if (lenEmpty && !IS_ISO) begin
            respHsNxt  = 1'b1;
            respPidNxt = RES_NAK;
          end else begin
            respPidNxt = (IS_ISO || !toggle) ? DATA_0 : DATA_1;
            zlpNxt     = lenEmpty;
            stateNxt   = SEND;
          end
        end
      end
      SEND: begin
        if (sie.txDone_i) begin
          if (IS_ISO) begin
            retire   = ~zlp;
            stateNxt = IDLE;
          end else begin
            stateNxt = WAIT_HS;
          end
        end
      end
      WAIT_HS: begin
        if (sie.hsAck_i) begin
          retire   = 1'b1;
          flip     = 1'b1;
          stateNxt = IDLE;
        end else if (sie.hsTimeout_i) begin
          rewind   = 1'b1;
          stateNxt = IDLE;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk12_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state                  <= IDLE;
      zlp                    <= 1'b0;
      toggle                 <= 1'b0;
      halted_o               <= 1'b0;
      rdSpec                 <= '0;
      rdPub                  <= '0;
      sie.respValid_o        <= 1'b0;
      sie.respHandshakePID_o <= 1'b0;
      sie.respPacketID_o     <= 2'd0;
    end else begin
      state                  <= stateNxt;
      zlp                    <= zlpNxt;
      sie.respValid_o        <= respValidNxt;
      sie.respHandshakePID_o <= respHsNxt;
      sie.respPacketID_o     <= respPidNxt;
      if (setHalt_i)        halted_o <= 1'b1;
      else if (clearHalt_i) halted_o <= 1'b0;
      // Configuration events beat a same-cycle ACK flip.
      if (clearHalt_i || resetDataToggle_i) toggle <= 1'b0;
      else if (flip)                        toggle <= ~toggle;
      if (retire) begin
        rdPub  <= pktEnd;
        rdSpec <= pktEnd;
      end else if (rewind) begin
        rdSpec <= rdPub;
      end else if (sie.popData_i && sie.dataAvailable_o) begin
        rdSpec <= rdSpec + PTR_WID'(1);
      end
    end
  end

endmodule

// File: doc/usb_endpoint_in_pktbuf.md
Name: usb_endpoint_in_pktbuf

Overview:
Parametrised, packet-buffered device-to-host endpoint. The application fills whole packets into a byte buffer. On each IN token the block chooses DATA0/DATA1, NAK or STALL, streams the packet to the SIE, and retires or rewinds it depending on the host handshake. It sits between the protocol engine's IN path and the application, and adds halt, NAK-on-empty, retry, max-packet enforcement and isochronous zero-length behaviour.

Parameters:
EP_TYPE, usb_ep_pkg::BULK, endpoint type (BULK/INTERRUPT/ISOCHRONOUS); NONE is illegal (elaboration error)
ADDR_WID, 9, data buffer address width (2^ADDR_WID bytes)
MAX_PKT_SIZE, 64, maximum payload bytes per packet (1..1023, <= 2^ADDR_WID)
NUM_PKTS, 4, packet-length FIFO depth (power of two, >= 2)

Ports:
clk12_i  in  1  12 MHz clock
rst_n_i  in  1  asynchronous active-low reset
resetDataToggle_i  in  1  configuration event; toggle := DATA0
setHalt_i  in  1  pulse; halt endpoint
clearHalt_i  in  1  pulse; unhalt and toggle := DATA0
fillValid_i  in  1  fillData_i valid this cycle
fillData_i  in  8  payload byte
fillCommit_i  in  1  close current packet (may be 0 bytes)
fillAbort_i  in  1  discard current partial packet
full_o  out  1  byte buffer full or length FIFO full
pktErr_o  out  1  1-cycle pulse: commit rejected (overflow)
pktCount_o  out  $clog2(NUM_PKTS)+1  committed packets pending
halted_o  out  1  halt state
inToken_i  in  1  1-cycle pulse: IN token addressed to this EP
respValid_o  out  1  response valid (1 cycle)
respHandshakePID_o  out  1  1 = handshake PID, 0 = data PID
respPacketID_o  out  2  usb_packet_pkg RES_* or DATA_0/DATA_1 code
popData_i  in  1  SIE consumes data_o
dataAvailable_o  out  1  byte of current packet available
isLast_o  out  1  data_o is last byte of packet
data_o  out  8  payload byte
txDone_i  in  1  SIE finished sending data packet
hsAck_i  in  1  host ACK received
hsTimeout_i  in  1  no valid handshake within timeout

Behaviour:
- Reset: all outputs 0 except full_o=0, halted_o=0; toggle=DATA0; FSM=IDLE; buffers empty.
- Fill: bytes are written at a speculative write pointer, and the per-packet byte count is tracked. A byte arriving while full, or the (MAX_PKT_SIZE+1)-th byte, sets an overflow flag and the byte is dropped. Commit with overflow set acts as an abort and pulses pktErr_o one cycle later. A valid commit pushes the length into the length FIFO and publishes the write pointer. Abort rewinds to the last published pointer. Commit and abort in the same cycle: abort wins. A byte together with commit in the same cycle belongs to the closing packet.
- FSM IDLE, on inToken_i, registered response at +1 cycle:
  - halted -> STALL handshake; stay IDLE.
  - else pktCount_o==0 and non-iso -> NAK handshake; stay IDLE.
  - else pktCount_o==0 and iso -> DATA0, zero-length; go SEND with dataAvailable_o=0.
  - else -> data PID (iso always DATA0, otherwise current toggle); go SEND.
- SEND: dataAvailable_o=1 while bytes remain. popData_i advances the speculative read pointer. isLast_o is asserted with the final byte. Pop while unavailable is ignored. On txDone_i: iso retires the packet and goes IDLE; non-iso goes WAIT_HS.
- WAIT_HS:
  - hsAck_i -> retire packet (publish read pointer, pop length, pktCount-1), flip toggle, go IDLE.
  - hsTimeout_i -> rewind read pointer to the packet start, keep toggle, go IDLE (retry resends identical data).
  - Both in the same cycle: ACK wins.
- Latency: response at token+1; first byte valid at token+1.
- inToken_i outside IDLE is ignored.
- Halt:
  - setHalt_i and clearHalt_i in the same cycle: set wins.
  - Halt mid-transaction does not abort it; only later tokens get STALL.
  - clearHalt_i, and resetDataToggle_i, override a same-cycle ACK toggle flip (toggle := DATA0).
- Pointers are ADDR_WID+1 bits with wrap bit; full when the pointers differ only in MSB.
- Fill and retire in the same cycle are both applied; pktCount_o stays consistent (+1-1).
- rst_n_i mid-transfer flushes all packets.

Decomposition:
- usb_ep_pkg: EndpointType enum.
- usb_packet_pkg: RES_ACK/RES_NAK/RES_STALL and DATA_0/DATA_1 response codes.
- Sub-module usb_ep_pkt_len_fifo: synchronous FIFO of $clog2(MAX_PKT_SIZE+1)-bit lengths, depth NUM_PKTS, with push/pop/full/empty/count.
- The byte buffer is inline dual-pointer BRAM with speculative/published pointers.

Test Plan:
- BULK: commit 3 bytes 0xA1,0xB2,0xC3; inToken; pop x3; txDone; hsAck -> DATA0, isLast_o on 0xC3, pktCount_o 1->0; next packet gets DATA1.
- Empty BULK inToken -> respHandshakePID_o=1, RES_NAK at +1. setHalt then inToken -> RES_STALL. clearHalt -> next data PID DATA0.
- Send 4-byte packet, hsTimeout_i; retry inToken -> same PID, identical 4 bytes; then ACK -> toggle flips once.
- Fill MAX_PKT_SIZE+1 (65) bytes, commit -> pktErr_o pulse, pktCount_o stays 0, buffer pointers unchanged.
- ISOCHRONOUS empty inToken -> DATA0, dataAvailable_o=0; txDone -> IDLE, no handshake wait.
- resetDataToggle_i in the same cycle as hsAck_i -> toggle DATA0; fill to 2^ADDR_WID bytes -> full_o=1, extra byte dropped.
